seq_divider16by8: RTL and testbench



---
 rtl/arith_pkg.sv | 7 +
 rtl/div_step.sv | 15 +
 rtl/seq_divider16by8.sv | 80 ++++++++
 tb/tb_seq_divider16by8.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for the arithmetic unit (multiplier/divider).
package arith_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;
  localparam logic [DEF_DW-1:0] DIV0_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (trial subtract, keep or restore) producing one quotient bit.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] r,
  input  logic          q_in,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] r_next,
  output logic          q_bit
);
  logic [VW:0] t;
  assign t      = {r, q_in} - {1'b0, d};
  assign q_bit  = ~t[VW];
  assign r_next = t[VW] ? {r[VW-2:0], q_in} : t[VW-1:0];
endmodule

// File: rtl/seq_divider16by8.sv
// seq_divider16by8: iterative restoring divider, DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to finish divide-by-zero in one edge and flag it on div_zero.
module seq_divider16by8
  import arith_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic          div_zero
`endif
);
  state_t state, state_next;
  logic [DW-1:0] q;
  logic [VW-1:0] d, r, r_next;
  logic [CW-1:0] cnt;
  logic q_bit, div0, accept;
`ifdef DIV_ZERO_DETECT_EN
  assign div0 = divisor == '0;
`else
  assign div0 = 1'b0;
`endif
  assign accept    = state == IDLE && in_valid;
  assign quotient  = q;
  assign remainder = r;
  div_step #(.VW(VW)) u_step (
    .r(r),
    .q_in(q[DW-1]),
    .d(d),
    .r_next(r_next),
    .q_bit(q_bit)
  );
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    in_ready   = state == IDLE;
    busy       = state == BUSY;
    out_valid  = state == DONE;
    state_next = (state == IDLE) ? (in_valid ? (div0 ? DONE : BUSY) : IDLE)
               : (state == BUSY) ? (cnt == CW'(1) ? DONE : BUSY)
               : (out_ready ? IDLE : DONE);
  end
  // The partial remainder is always below the divisor, so its (VW+1)-th bit is never stored.
  always_ff @(posedge clk)
    if (!rst_n) begin
      q   <= '0;
      d   <= '0;
      r   <= '0;
      cnt <= '0;
    end else if (accept) begin
      q   <= div0 ? '1 : dividend;
      d   <= divisor;
      r   <= div0 ? dividend[VW-1:0] : '0;
      cnt <= CW'(DW);
    end else if (state == BUSY) begin
      r   <= r_next;
      q   <= {q[DW-2:0], q_bit};
      cnt <= cnt - CW'(1);
    end
`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk)
    if (!rst_n) div_zero <= 1'b0;
    else if (accept) div_zero <= div0;
    else if (state == DONE && out_ready) div_zero <= 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider16by8.sv
// tb_seq_divider16by8: directed-vector bench for seq_divider16by8 with a round-trip multiply/divide sweep.
module tb_seq_divider16by8;
  import arith_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic in_ready, out_valid, busy;
  logic [15:0] quotient;
  logic [7:0] remainder;
  int checks = 0, errors = 0;
`ifdef DIV_ZERO_DETECT_EN
  logic div_zero;
`endif
  seq_divider16by8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_zero(div_zero)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [15:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask
  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b,
                     input logic [15:0] eq, input logic [7:0] er, input int elat);
    int lat;
    start(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
`ifdef DIV_ZERO_DETECT_EN
    chk({tag, "_dz"}, div_zero, b == 8'd0);
`endif
    take();
    chk({tag, "_rdy"}, in_ready, 1);
  endtask
  initial begin
    int lat, seen;
    logic [15:0] q_hold;
    logic [7:0] r_hold;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    rst_n = 1'b1;
    tick();
    // reset while 1000/7 is in flight: no result may ever appear
    start(16'd1000, 8'd7);
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    chk("mid_in_ready", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_busy", busy, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mrst_no_result", seen, 0);
    run("d20_3", 16'd20, 8'd3, 16'd6, 8'd2, 17);
    run("max", 16'hFFFF, 8'hFF, 16'd257, 8'd0, 17);
    run("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 17);
    run("by_one", 16'h1234, 8'd1, 16'h1234, 8'd0, 17);
    run("small", 16'd5, 8'd10, 16'd0, 8'd5, 17);
    run("zero_num", 16'd0, 8'd3, 16'd0, 8'd0, 17);
`ifdef DIV_ZERO_DETECT_EN
    run("div0", 16'h00AB, 8'd0, DIV0_QUOT, 8'hAB, 1);
`else
    run("div0", 16'h00AB, 8'd0, DIV0_QUOT, 8'hAB, 17);
`endif
    // backpressure: result must hold and new operands be ignored
    start(16'd200, 8'd9);
    wait_done(lat);
    chk("bp_lat", lat, 17);
    q_hold = 16'd22;
    r_hold = 8'd2;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 16'd999;
      divisor  = 8'd1;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_q", quotient, q_hold);
      chk("bp_r", remainder, r_hold);
    end
    in_valid = 1'b0;
    take();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_rdy", in_ready, 1);
    chk("bp_release_busy", busy, 0);
    // round trip against the multiplier relation, model is plain / and %
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic [15:0] p;
      a = 8'($urandom_range(1, 255));
      b = 8'($urandom_range(1, 255));
      p = 16'(a) * 16'(b);
      start(p, b);
      wait_done(lat);
      chk("rt_lat", lat, 17);
      chk("rt_q", quotient, p / 16'(b));
      chk("rt_a", quotient, 16'(a));
      chk("rt_r", remainder, 8'(p % 16'(b)));
      take();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
